fifo_rd_packer: RTL and testbench

Read-side consumer of the asynchronous FIFO, clocked in the read domain. It drains DSIZE-bit words through the FIFO's synchronous-read port (`ren` / `rdata` / `empty`) and packs RATIO consecutive words into one wide output word. Packed words leave on a valid/ready stream through a 2-entry output queue. A `flush` request emits a partial word with a lane mask, so downstream frame logic never waits on a half-filled word.

---
 rtl/fifo_rd_packer_if.sv | 26 ++
 rtl/fifo_rd_packer.sv | 160 ++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port, flush request and packed output stream of fifo_rd_packer
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic                    empty;
    logic                    ren;
    logic [DSIZE-1:0]        rdata;
    logic                    flush;
    logic                    o_valid;
    logic                    o_ready;
    logic [DSIZE*RATIO-1:0]  o_data;
    logic [RATIO-1:0]        o_keep;
    logic                    o_last;
    logic [15:0]             rd_count;

    // master is the packer itself; slave is the FIFO plus downstream side
    modport master (
        input  empty, rdata, flush, o_ready,
        output ren, o_valid, o_data, o_keep, o_last, rd_count
    );
    modport slave (
        output empty, rdata, flush, o_ready,
        input  ren, o_valid, o_data, o_keep, o_last, rd_count
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains a sync-read FIFO and packs RATIO words into one wide word with flush support
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    localparam int ODSIZE = DSIZE * RATIO
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_rd_packer_if.master bus
);
    localparam int IW = $clog2(RATIO);
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               rd_vld_q, rd_vld_d;
    logic [ODSIZE-1:0]  acc_data_q, acc_data_d;
    logic [RATIO-1:0]   acc_keep_q, acc_keep_d;
    logic [15:0]        rd_count_q, rd_count_d;
    logic [1:0]         q_cnt_q, q_cnt_d;
    logic [ODSIZE-1:0]  e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [RATIO-1:0]   e0_keep_q, e0_keep_d, e1_keep_q, e1_keep_d;
    logic               e0_last_q, e0_last_d, e1_last_q, e1_last_d;

    logic               ren, push_pend, flush_done, push, pop;
    logic [ODSIZE-1:0]  lane_data, push_data;
    logic [RATIO-1:0]   lane_keep, push_keep;
    logic               push_last;

    assign push_pend = rd_vld_q && (idx_q == LAST_IDX);
    // Space is reserved for a word that is about to complete, so a completion never meets a full queue
    assign ren = !rrst && !bus.empty && (state_q == FILL) && ((q_cnt_q + {1'b0, push_pend}) < 2'd2);
    // A flush that lands exactly on a completing word with nothing else in flight just closes that word
    assign flush_done = (state_q == FILL) && bus.flush && push_pend && !ren;
    assign pop = (q_cnt_q != 2'd0) && bus.o_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_vld_d   = ren;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        rd_count_d = rd_count_q;
        lane_data  = acc_data_q;
        lane_keep  = acc_keep_q;
        push       = 1'b0;
        push_data  = lane_data;
        push_keep  = '1;
        push_last  = 1'b0;

        if (rd_vld_q) begin
            lane_data[int'(idx_q)*DSIZE +: DSIZE] = bus.rdata;
            lane_keep[idx_q] = 1'b1;
            rd_count_d = rd_count_q + 16'd1;
            if (idx_q == LAST_IDX) begin
                idx_d      = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
                push       = 1'b1;
                push_data  = lane_data;
                push_last  = (state_q != FILL) || flush_done;
            end else begin
                idx_d      = idx_q + IW'(1);
                acc_data_d = lane_data;
                acc_keep_d = lane_keep;
            end
        end

        case (state_q)
            FILL: begin
                if (bus.flush && !((idx_q == '0) && !rd_vld_q) && !flush_done)
                    state_d = ren ? DRAIN : EMIT;
            end
            DRAIN: begin
                state_d = push_pend ? FILL : EMIT;
            end
            EMIT: begin
                if (q_cnt_q < 2'd2) begin
                    push       = 1'b1;
                    push_data  = acc_data_q;
                    push_keep  = acc_keep_q;
                    push_last  = 1'b1;
                    acc_data_d = '0;
                    acc_keep_d = '0;
                    idx_d      = '0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Two-entry queue, entry 0 is the head
    always_comb begin
        e0_data_d = e0_data_q;
        e0_keep_d = e0_keep_q;
        e0_last_d = e0_last_q;
        e1_data_d = e1_data_q;
        e1_keep_d = e1_keep_q;
        e1_last_d = e1_last_q;
        if (pop) begin
            e0_data_d = e1_data_q;
            e0_keep_d = e1_keep_q;
            e0_last_d = e1_last_q;
        end
        if (push) begin
            if ((q_cnt_q == 2'd0) || ((q_cnt_q == 2'd1) && pop)) begin
                e0_data_d = push_data;
                e0_keep_d = push_keep;
                e0_last_d = push_last;
            end else begin
                e1_data_d = push_data;
                e1_keep_d = push_keep;
                e1_last_d = push_last;
            end
        end
        q_cnt_d = q_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q    <= FILL;
            idx_q      <= '0;
            rd_vld_q   <= 1'b0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            rd_count_q <= '0;
            q_cnt_q    <= '0;
            e0_data_q  <= '0;
            e0_keep_q  <= '0;
            e0_last_q  <= 1'b0;
            e1_data_q  <= '0;
            e1_keep_q  <= '0;
            e1_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_vld_q   <= rd_vld_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            rd_count_q <= rd_count_d;
            q_cnt_q    <= q_cnt_d;
            e0_data_q  <= e0_data_d;
            e0_keep_q  <= e0_keep_d;
            e0_last_q  <= e0_last_d;
            e1_data_q  <= e1_data_d;
            e1_keep_q  <= e1_keep_d;
            e1_last_q  <= e1_last_d;
        end
    end

    assign bus.ren      = ren;
    assign bus.o_valid  = (q_cnt_q != 2'd0);
    assign bus.o_data   = e0_data_q;
    assign bus.o_keep   = e0_keep_q;
    assign bus.o_last   = e0_last_q;
    assign bus.rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed bench for fifo_rd_packer with a FIFO read-port model
module tb_fifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int RATIO = 4;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus();
    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (.rclk(rclk), .rrst(rrst), .bus(bus));

    always #5 rclk = ~rclk;

    // FIFO model: registered read data one cycle after an accepted ren
    logic [7:0] mem [0:2047];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic hold_empty = 1'b0;
    assign bus.empty = hold_empty || (wr_ptr == rd_ptr);
    always @(posedge rclk) begin
        if (bus.ren) begin
            bus.rdata <= mem[rd_ptr % 2048];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [31:0] od [$];
    logic [3:0]  ok [$];
    logic        ol [$];
    int viol_empty = 0;
    int viol_full  = 0;
    always @(negedge rclk) begin
        if (!rrst && bus.o_valid && bus.o_ready) begin
            od.push_back(bus.o_data);
            ok.push_back(bus.o_keep);
            ol.push_back(bus.o_last);
        end
        if (bus.ren && bus.empty) viol_empty++;
        if (dut.push && dut.q_cnt_q == 2'd2) viol_full++;
    end

    logic [7:0] gb [1000];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic fifo_put(logic [7:0] d);
        mem[wr_ptr % 2048] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_words(int n, int budget);
        int c = 0;
        while (od.size() < n && c < budget) begin
            @(negedge rclk);
            c++;
        end
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #1;
        rrst = 1'b1;
        bus.flush = 1'b0;
        hold_empty = 1'b0;
        tick(2);
        rrst = 1'b0;
        od.delete();
        ok.delete();
        ol.delete();
    endtask

    initial begin
        int c;
        int start;
        int bad;
        bus.flush   = 1'b0;
        bus.o_ready = 1'b0;
        tick(3);
        @(negedge rclk);
        check("rst_ren", bus.ren, 0);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_data", bus.o_data, 0);
        check("rst_o_keep", bus.o_keep, 0);
        check("rst_o_last", bus.o_last, 0);
        check("rst_rd_count", bus.rd_count, 0);
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        tick(1);

        // basic packing and fill latency
        bus.o_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_put(8'(i * 8'h11));
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (bus.o_valid) break;
            c++;
        end
        check("fill_latency", c, 5);
        wait_words(2, 40);
        tick(4);
        check("basic_count", od.size(), 2);
        check("basic_w0", od[0], 32'h44332211);
        check("basic_k0", ok[0], 4'hF);
        check("basic_l0", ol[0], 0);
        check("basic_w1", od[1], 32'h88776655);
        check("basic_k1", ok[1], 4'hF);
        check("basic_l1", ol[1], 0);
        check("basic_rd_count", bus.rd_count, 8);

        // backpressure
        do_reset();
        bus.o_ready = 1'b0;
        start = rd_ptr;
        for (int i = 1; i <= 16; i++) fifo_put(8'(i));
        tick(40);
        check("bp_consumed", rd_ptr - start, 8);
        check("bp_rd_count", bus.rd_count, 8);
        check("bp_o_valid", bus.o_valid, 1);
        check("bp_head", bus.o_data, 32'h04030201);
        tick(5);
        check("bp_head_stable", bus.o_data, 32'h04030201);
        bus.o_ready = 1'b1;
        wait_words(4, 60);
        tick(4);
        check("bp_count", od.size(), 4);
        check("bp_w0", od[0], 32'h04030201);
        check("bp_w1", od[1], 32'h08070605);
        check("bp_w2", od[2], 32'h0C0B0A09);
        check("bp_w3", od[3], 32'h100F0E0D);
        check("bp_rd_count_end", bus.rd_count, 16);

        // partial flush from an idle FIFO
        do_reset();
        bus.o_ready = 1'b1;
        fifo_put(8'hA1);
        fifo_put(8'hA2);
        fifo_put(8'hA3);
        tick(8);
        bus.flush = 1'b1;
        @(negedge rclk);
        @(posedge rclk);
        #1;
        bus.flush = 1'b0;
        @(negedge rclk);
        check("flush_early", bus.o_valid, 0);
        @(negedge rclk);
        check("flush_latency", bus.o_valid, 1);
        wait_words(1, 20);
        check("pf_count", od.size(), 1);
        check("pf_w", od[0], 32'h00A3A2A1);
        check("pf_k", ok[0], 4'b0111);
        check("pf_l", ol[0], 1);
        for (int i = 1; i <= 4; i++) fifo_put(8'(8'hB0 + i));
        wait_words(2, 30);
        tick(2);
        check("pf_next_count", od.size(), 2);
        check("pf_next_w", od[1], 32'hB4B3B2B1);
        check("pf_next_k", ok[1], 4'hF);
        check("pf_next_l", ol[1], 0);

        // flush with nothing accumulated is a no-op
        do_reset();
        bus.o_ready = 1'b1;
        tick(3);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        tick(10);
        check("noop_flush_words", od.size(), 0);
        for (int i = 1; i <= 4; i++) fifo_put(8'(8'hE0 + i));
        wait_words(1, 30);
        tick(2);
        check("noop_next_count", od.size(), 1);
        check("noop_next_w", od[0], 32'hE4E3E2E1);
        check("noop_next_l", ol[0], 0);

        // flush in the cycle of the 4th ren
        for (int i = 1; i <= 4; i++) fifo_put(8'(8'hC0 + i));
        tick(3);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        wait_words(2, 20);
        tick(10);
        check("f4_count", od.size(), 2);
        check("f4_w", od[1], 32'hC4C3C2C1);
        check("f4_k", ok[1], 4'hF);
        check("f4_l", ol[1], 1);

        // random empty gating and backpressure over 1000 words
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            gb[i] = 8'($urandom);
            fifo_put(gb[i]);
        end
        c = 0;
        while (od.size() < 250 && c < 20000) begin
            hold_empty  = ($urandom_range(0, 3) == 0);
            bus.o_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            c++;
        end
        hold_empty  = 1'b0;
        bus.o_ready = 1'b1;
        tick(4);
        check("rand_count", od.size(), 250);
        bad = 0;
        for (int k = 0; k < 250 && k < od.size(); k++) begin
            if (od[k] !== {gb[4*k+3], gb[4*k+2], gb[4*k+1], gb[4*k]} || ok[k] !== 4'hF || ol[k] !== 1'b0)
                bad++;
        end
        check("rand_stream_bad", bad, 0);
        check("rand_rd_count", bus.rd_count, 1000);

        // async reset mid-word
        do_reset();
        bus.o_ready = 1'b0;
        for (int i = 1; i <= 6; i++) fifo_put(8'(8'hF0 + i));
        tick(7);
        check("ar_pre_valid", bus.o_valid, 1);
        check("ar_pre_count", bus.rd_count, 6);
        @(negedge rclk);
        #2;
        rrst = 1'b1;
        #1;
        check("ar_ren", bus.ren, 0);
        check("ar_o_valid", bus.o_valid, 0);
        check("ar_o_data", bus.o_data, 0);
        check("ar_o_keep", bus.o_keep, 0);
        check("ar_o_last", bus.o_last, 0);
        check("ar_rd_count", bus.rd_count, 0);
        tick(2);
        rrst = 1'b0;
        od.delete();
        ok.delete();
        ol.delete();
        bus.o_ready = 1'b1;
        for (int i = 1; i <= 4; i++) fifo_put(8'(8'hD0 + i));
        wait_words(1, 30);
        tick(3);
        check("ar_post_count", od.size(), 1);
        check("ar_post_w", od[0], 32'hD4D3D2D1);
        check("ar_post_k", ok[0], 4'hF);
        check("ar_post_l", ol[0], 0);
        check("ar_post_rd_count", bus.rd_count, 4);

        check("ren_while_empty", viol_empty, 0);
        check("push_into_full", viol_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
